// File: rtl/count_accumulator.sv
// Gated multi-channel pulse counter with a fixed-length collection window.
// Define CNT_SATURATE_EN to saturate counters at 2^CW-1 instead of wrapping.
module count_accumulator #(
    parameter int N_CH       = 53,
    parameter int CW         = 10,
    parameter int INT_CYCLES = 50000000
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               cnt_start,
    input  logic               cnt_clr,
    input  logic [N_CH-1:0]    det_in,
    output logic [N_CH*CW-1:0] counts,
    output logic               collect_done,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_e;

    localparam logic [25:0] LAST = 26'(INT_CYCLES - 1);

    state_e          state_q;
    logic [25:0]     timer_q;
    logic [N_CH-1:0] s1_q, s2_q, s3_q;
    logic [1:0]      warm_q;
    logic [N_CH-1:0] det_edge;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];

    // Edges are masked until the synchroniser has refilled after reset.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            warm_q <= '0;
        end else begin
            s1_q <= det_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign det_edge = s2_q & ~s3_q & {N_CH{warm_q == 2'd3}};

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (det_edge[i]) begin
`ifdef CNT_SATURATE_EN
                if (cnt_q[i] != {CW{1'b1}}) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
`else
                cnt_d[i] = cnt_q[i] + CW'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            cnt_q        <= '{default: '0};
            collect_done <= 1'b0;
            busy         <= 1'b0;
        end else if (cnt_clr) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            cnt_q        <= '{default: '0};
            collect_done <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cnt_start) begin
                        state_q <= S_COLLECT;
                        timer_q <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    cnt_q   <= cnt_d;
                    timer_q <= timer_q + 26'd1;
                    if (timer_q == LAST) begin
                        state_q      <= S_DONE;
                        collect_done <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    collect_done <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        counts = '0;
        for (int i = 0; i < N_CH; i++) begin
            counts[CW*i +: CW] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_count_accumulator.sv
// Directed bench for count_accumulator: window timing, edge gating,
// clear/start priority, reset abort and counter overflow.
`timescale 1ns/1ps
module tb_count_accumulator;

    localparam int N_CH = 53;
    localparam int CW   = 10;
    localparam int W    = N_CH * CW;

    logic            clk50     = 1'b0;
    logic            rst_n     = 1'b0;
    logic            cnt_start = 1'b0;
    logic            cnt_clr   = 1'b0;
    logic            big_start = 1'b0;
    logic [N_CH-1:0] det_in    = '0;
    logic [W-1:0]    counts, big_counts;
    logic            collect_done, busy;
    logic            big_done, big_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0;
    int n;
    logic [W-1:0] e;
    logic [CW-1:0] big_exp;

    always #10 clk50 = ~clk50;
    always @(posedge clk50) cyc++;

    count_accumulator #(
        .N_CH(N_CH), .CW(CW), .INT_CYCLES(100)
    ) dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .cnt_start   (cnt_start),
        .cnt_clr     (cnt_clr),
        .det_in      (det_in),
        .counts      (counts),
        .collect_done(collect_done),
        .busy        (busy)
    );

    // Long window so 1030 legal-width pulses fit in one collection.
    count_accumulator #(
        .N_CH(N_CH), .CW(CW), .INT_CYCLES(5000)
    ) u_big (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .cnt_start   (big_start),
        .cnt_clr     (cnt_clr),
        .det_in      (det_in),
        .counts      (big_counts),
        .collect_done(big_done),
        .busy        (big_busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk50);
        #1;
    endtask

    task automatic pulse(input int ch);
        det_in[ch] = 1'b1;
        tick(2);
        det_in[ch] = 1'b0;
        tick(2);
    endtask

    task automatic start_win();
        cnt_start = 1'b1;
        tick(1);
        cnt_start = 1'b0;
    endtask

    task automatic clear();
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!collect_done && k < 300) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        tick(3);
        chk("rst_counts", counts, '0);
        chk("rst_done", collect_done, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(3);

        // basic window
        start_win();
        t0 = cyc;
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 7; i++) pulse(0);
        for (int i = 0; i < 3; i++) pulse(52);
        wait_done(n);
        chk("t1_latency", cyc - t0, 100);
        e = '0;
        e[0 +: CW] = 10'd7;
        e[52*CW +: CW] = 10'd3;
        chk("t1_counts", counts, e);
        chk("t1_busy_done", busy, 0);

        // clear and start together in DONE
        cnt_clr   = 1'b1;
        cnt_start = 1'b1;
        tick(1);
        cnt_clr   = 1'b0;
        cnt_start = 1'b0;
        chk("t2_counts", counts, '0);
        chk("t2_done", collect_done, 0);
        chk("t2_busy", busy, 0);
        tick(5);
        chk("t2_nostart", busy, 0);

        // edge in final collect cycle counted
        start_win();
        tick(97);
        det_in[5] = 1'b1;
        tick(2);
        det_in[5] = 1'b0;
        wait_done(n);
        e = '0;
        e[5*CW +: CW] = 10'd1;
        chk("t3_last_cycle", counts, e);

        // one cycle later is lost; counts frozen in DONE
        clear();
        start_win();
        tick(98);
        pulse(5);
        wait_done(n);
        pulse(5);
        pulse(3);
        chk("t3_late", counts, '0);
        chk("t3_hold_done", collect_done, 1);

        // second start mid-window ignored
        clear();
        start_win();
        t0 = cyc;
        tick(40);
        cnt_start = 1'b1;
        tick(1);
        cnt_start = 1'b0;
        pulse(7);
        wait_done(n);
        chk("t4_latency", cyc - t0, 100);
        e = '0;
        e[7*CW +: CW] = 10'd1;
        chk("t4_counts", counts, e);

        // reset mid-window with det_in[2] held high through release
        clear();
        start_win();
        tick(50);
        det_in[2] = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        chk("t5_counts", counts, '0);
        chk("t5_done", collect_done, 0);
        chk("t5_busy", busy, 0);
        rst_n     = 1'b1;
        cnt_start = 1'b1;
        tick(1);
        cnt_start = 1'b0;
        t0 = cyc;
        wait_done(n);
        det_in[2] = 1'b0;
        chk("t5_latency", cyc - t0, 100);
        chk("t5_no_ch2", counts, '0);

        // overflow on a long window
        clear();
        big_start = 1'b1;
        tick(1);
        big_start = 1'b0;
        for (int i = 0; i < 1030; i++) pulse(1);
        n = 0;
        while (!big_done && n < 6000) begin
            tick(1);
            n++;
        end
        chk("t6_big_done", big_done, 1);
`ifdef CNT_SATURATE_EN
        big_exp = 10'd1023;
`else
        big_exp = 10'd6;
`endif
        chk("t6_overflow", big_counts[CW +: CW], big_exp);
        chk("t6_idle_hold", counts, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_accumulator.md
COUNT_ACCUMULATOR -- requirements
Module: count_accumulator

Interface
REQ-001 SHALL have parameter N_CH, default 53: number of detector channels.
REQ-002 SHALL have parameter CW, default 10: count width per channel.
REQ-003 SHALL have parameter INT_CYCLES, default 50000000: collection window length in clk50 cycles (1 s); legal range 2..2^26-1.
REQ-004 SHALL have port clk50  input  1  system clock, 50 MHz; one clock; all flops on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cnt_start  input  1  one-cycle request to open a collection window; sync to clk50.
REQ-007 SHALL have port cnt_clr  input  1  one-cycle request to clear counts and return to idle; sync to clk50.
REQ-008 SHALL have port det_in  input  N_CH  asynchronous detector discriminator pulses, one per channel.
REQ-009 SHALL have port counts  output  N_CH*CW  flat count bus; channel i at bits [CW*i+CW-1 : CW*i].
REQ-010 SHALL have port collect_done  output  1  high while the completed window's counts are held for readout.
REQ-011 SHALL have port busy  output  1  high while a collection window is open.

Function
REQ-012 SHALL pass each det_in bit through a 2-flop synchroniser plus a third history flop; edge = stage2 high AND stage3 low.
REQ-013 SHALL increment channel i's counter on the clock edge after its edge is detected; det_in rising edge to counter change = 3 clk50 cycles.
REQ-014 SHALL count only edges on det_in held high >= 2 and low >= 2 clk50 periods; shorter pulses may be missed, never double-counted.
REQ-015 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-016 IDLE: counters and window timer hold; collect_done=0, busy=0; cnt_start -> COLLECT with timer=0.
REQ-017 COLLECT: busy=1; timer increments each cycle; detected edges counted; when timer = INT_CYCLES-1 -> DONE on next edge.
REQ-018 SHALL count edges detected in the final COLLECT cycle; edges detected in DONE or IDLE SHALL be discarded.
REQ-019 DONE: collect_done=1, busy=0; counts frozen and stable until cnt_clr.
REQ-020 cnt_start in COLLECT or DONE SHALL be ignored.
REQ-021 cnt_clr in any state SHALL, on the next edge, zero all counters and the timer and enter IDLE.
REQ-022 cnt_clr and cnt_start asserted together SHALL act as cnt_clr alone; the start is dropped.
REQ-023 counts SHALL be driven directly from the counter registers (no output latency beyond REQ-013).
REQ-024 Timer width SHALL be 26 bits; all comparisons unsigned.

Reset
REQ-025 On rst_n low: state=IDLE, all counters=0, timer=0, all synchroniser/history flops=0, collect_done=0, busy=0, counts=0.
REQ-026 Reset asserted mid-window SHALL abort the window; no collect_done after release until a new cnt_start completes a window.
REQ-027 Release of rst_n while det_in is high SHALL NOT produce a count (history flops start at 0 but synchroniser needs 2 cycles; edge is suppressed for 3 cycles after release).

Configuration
REQ-028 Macro CNT_SATURATE_EN defined: a counter at 2^CW-1 SHALL hold at 2^CW-1 on further edges (1023 for CW=10).
REQ-029 Macro CNT_SATURATE_EN undefined: counters SHALL wrap modulo 2^CW (1023 + 1 -> 0).

Verification
REQ-030 INT_CYCLES=100; reset, cnt_start, 7 clean pulses on det_in[0], 3 on det_in[52] -> collect_done rises exactly 100 cycles after start; counts ch0=7, ch52=3, others 0.
REQ-031 Pulse on det_in[5] whose synchronised edge lands in the last COLLECT cycle -> counted; an identical pulse one cycle later -> not counted; counts frozen through DONE.
REQ-032 1030 pulses on det_in[1] in one window -> 1023 with CNT_SATURATE_EN, 6 without.
REQ-033 cnt_clr and cnt_start in the same cycle during DONE -> next cycle IDLE, counts all 0, collect_done=0, busy=0; window not started.
REQ-034 rst_n pulsed low at timer=50 with det_in[2] held high through release -> all outputs 0; no count for ch2; new cnt_start gives full 100-cycle window.
REQ-035 Second cnt_start at timer=40 -> ignored; collect_done still at 100 cycles after the first start.
